// File: rtl/handshake_elastic_fifo.sv
// Elastic N-slot FIFO for a dataflow valid/ready channel. It decouples producer
// and consumer, registers the ready path and re-emits tokens in arrival order.
module handshake_elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            ins,
  input  logic                             ins_valid,
  output logic                             ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic                             outs_valid,
  input  logic                             outs_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Valid never waits on ready; both readies here come from
  // registered state only, so a full FIFO refuses input even while popping.
  assign ins_ready  = !rst && (cnt != FULL_CNT);
  assign outs_valid = !rst && (cnt != '0);
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;
  assign outs       = outs_valid ? mem[rd_ptr] : '0;
  assign occupancy  = rst ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ins;
  end

`ifndef SYNTHESIS
  a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) cnt <= FULL_CNT);
  a_no_ovf:     assert property (@(posedge clk) disable iff (rst) !(push && cnt == FULL_CNT));
  a_no_udf:     assert property (@(posedge clk) disable iff (rst) !(pop && cnt == '0));
`endif

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: a 4-slot and a 3-slot instance, each checked
// against a queue-based reference model updated at every clock edge.
module tb_handshake_elastic_fifo;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] a_ins, a_outs, b_ins, b_outs;
  logic a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
  logic b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;
  logic [2:0] a_occ;
  logic [1:0] b_occ;

  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] b_exp_q[$];
  int checks = 0;
  int errors = 0;

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(4)) dut_a (
    .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready), .occupancy(a_occ)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready), .occupancy(b_occ)
  );

  function automatic logic [W-1:0] a_head();
    return (a_exp_q.size() != 0) ? a_exp_q[0] : '0;
  endfunction

  function automatic logic [W-1:0] b_head();
    return (b_exp_q.size() != 0) ? b_exp_q[0] : '0;
  endfunction

  // Advance the reference model with the inputs present at the coming edge.
  task automatic tick();
    bit a_push, a_pop, b_push, b_pop;
    if (rst) begin
      a_exp_q.delete();
      b_exp_q.delete();
    end else begin
      a_pop  = a_outs_ready && (a_exp_q.size() != 0);
      a_push = a_ins_valid && (a_exp_q.size() != 4);
      b_pop  = b_outs_ready && (b_exp_q.size() != 0);
      b_push = b_ins_valid && (b_exp_q.size() != 3);
      if (a_pop)  void'(a_exp_q.pop_front());
      if (a_push) a_exp_q.push_back(a_ins);
      if (b_pop)  void'(b_exp_q.pop_front());
      if (b_push) b_exp_q.push_back(b_ins);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_ins_valid = 1'b1;
    a_ins = 32'd55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL rst_ins_ready got %b exp 0", a_ins_ready); end
      checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL rst_outs_valid got %b exp 0", a_outs_valid); end
      checks++; if (a_outs !== '0) begin errors++; $display("FAIL rst_outs got %0h exp 0", a_outs); end
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", a_occ); end
      checks++; if (b_ins_ready !== 1'b0 || b_outs_valid !== 1'b0) begin errors++; $display("FAIL rst_b_flags got %b%b exp 00", b_ins_ready, b_outs_valid); end
      tick();
    end
    rst = 1'b0;
    a_ins_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_ins_ready !== 1'b1) begin errors++; $display("FAIL idle_ins_ready got %b exp 1", a_ins_ready); end
      checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL idle_outs_valid got %b exp 0", a_outs_valid); end
      checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL idle_occ got %0d exp 0", a_occ); end
      checks++; if (b_ins_ready !== 1'b1 || b_occ !== 2'd0) begin errors++; $display("FAIL idle_b got rdy %b occ %0d exp 1 0", b_ins_ready, b_occ); end
      tick();
    end
  endtask

  task automatic test_single_token();
    a_ins = 32'd21;
    a_ins_valid = 1'b1;
    a_outs_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL single_bypass got %b exp 0", a_outs_valid); end
    tick();
    a_ins_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_outs_valid !== 1'b1 || a_outs !== 32'd21) begin errors++; $display("FAIL single_out got %b/%0d exp 1/21", a_outs_valid, a_outs); end
    checks++; if (a_occ !== 3'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", a_occ); end
    tick();
    @(negedge clk);
    checks++; if (a_occ !== 3'd0 || a_outs_valid !== 1'b0) begin errors++; $display("FAIL single_occ0 got %0d/%b exp 0/0", a_occ, a_outs_valid); end
    tick();
    a_outs_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    a_outs_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_ins = W'(i);
      a_ins_valid = 1'b1;
      @(negedge clk);
      checks++; if (a_ins_ready !== 1'b1 || a_occ !== 3'(i - 1)) begin errors++; $display("FAIL fill_push%0d got rdy %b occ %0d exp 1 %0d", i, a_ins_ready, a_occ, i - 1); end
      tick();
    end
    a_ins = 32'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_occ !== 3'd4 || a_ins_ready !== 1'b0) begin errors++; $display("FAIL fill_full got occ %0d rdy %b exp 4 0", a_occ, a_ins_ready); end
      checks++; if (a_outs_valid !== 1'b1 || a_outs !== 32'd1) begin errors++; $display("FAIL fill_hold got %b/%0d exp 1/1", a_outs_valid, a_outs); end
      tick();
    end
    a_outs_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_ins_ready !== 1'b0) begin errors++; $display("FAIL fill_pop_full_rdy got %b exp 0", a_ins_ready); end
    tick();
    a_outs_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_ins_ready !== 1'b1 || a_occ !== 3'd3 || a_outs !== 32'd2) begin errors++; $display("FAIL fill_after_pop got rdy %b occ %0d outs %0d exp 1 3 2", a_ins_ready, a_occ, a_outs); end
    tick();
    a_ins_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL fill_accept5 got occ %0d exp 4", a_occ); end
    tick();
    a_outs_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (a_outs_valid !== 1'b1 || a_outs !== W'(k + 2)) begin errors++; $display("FAIL fill_drain%0d got %b/%0d exp 1/%0d", k, a_outs_valid, a_outs, k + 2); end
      tick();
    end
    @(negedge clk);
    checks++; if (a_occ !== 3'd0 || a_outs_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %0d/%b exp 0/0", a_occ, a_outs_valid); end
    a_outs_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [W-1:0] got[$];
    int next_tok = 0;
    int cyc = 0;
    while (got.size() < 10 && cyc < 200) begin
      b_ins_valid  = (next_tok < 10);
      b_ins        = W'(next_tok);
      b_outs_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (b_outs_valid !== (b_exp_q.size() != 0) || b_outs !== b_head()) begin errors++; $display("FAIL wrap_head got %b/%0d exp %0d/%0d", b_outs_valid, b_outs, b_exp_q.size() != 0, b_head()); end
      checks++; if (b_occ !== 2'(b_exp_q.size())) begin errors++; $display("FAIL wrap_occ got %0d exp %0d", b_occ, b_exp_q.size()); end
      if (b_outs_valid && b_outs_ready) got.push_back(b_outs);
      if (b_ins_valid && b_exp_q.size() != 3) next_tok++;
      tick();
      cyc++;
    end
    b_ins_valid = 1'b0;
    b_outs_ready = 1'b0;
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count got %0d exp 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== W'(i)) begin errors++; $display("FAIL wrap_order idx %0d got %0d exp %0d", i, got[i], i); end
    end
  endtask

  task automatic test_back_to_back();
    a_outs_ready = 1'b0;
    a_ins_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_ins = W'(100 + i);
      @(negedge clk);
      tick();
    end
    a_outs_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_ins = W'(102 + i);
      @(negedge clk);
      checks++; if (a_occ !== 3'd2 || a_ins_ready !== 1'b1) begin errors++; $display("FAIL b2b_occ%0d got occ %0d rdy %b exp 2 1", i, a_occ, a_ins_ready); end
      checks++; if (a_outs_valid !== 1'b1 || a_outs !== W'(100 + i)) begin errors++; $display("FAIL b2b_out%0d got %b/%0d exp 1/%0d", i, a_outs_valid, a_outs, 100 + i); end
      tick();
    end
    a_ins_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (a_outs !== W'(108 + k)) begin errors++; $display("FAIL b2b_drain%0d got %0d exp %0d", k, a_outs, 108 + k); end
      tick();
    end
    a_outs_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_outs_ready = 1'b0;
    a_ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_ins = $urandom;
      @(negedge clk);
      tick();
    end
    a_ins_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_outs_valid !== 1'b0 || a_outs !== '0 || a_ins_ready !== 1'b0 || a_occ !== 3'd0) begin errors++; $display("FAIL midrst_during got v %b d %0h r %b occ %0d exp 0 0 0 0", a_outs_valid, a_outs, a_ins_ready, a_occ); end
    tick();
    rst = 1'b0;
    a_ins = 32'd7;
    a_ins_valid = 1'b1;
    @(negedge clk);
    checks++; if (a_occ !== 3'd0 || a_outs_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got occ %0d v %b exp 0 0", a_occ, a_outs_valid); end
    tick();
    a_ins_valid = 1'b0;
    a_outs_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_outs_valid !== 1'b1 || a_outs !== 32'd7 || a_occ !== 3'd1) begin errors++; $display("FAIL midrst_new got %b/%0d occ %0d exp 1/7 1", a_outs_valid, a_outs, a_occ); end
    tick();
    @(negedge clk);
    checks++; if (a_outs_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got %b exp 0", a_outs_valid); end
    tick();
    a_outs_ready = 1'b0;
  endtask

  task automatic test_random();
    a_ins_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_ins_valid) begin
        a_ins_valid = 1'($urandom_range(0, 1));
        a_ins = $urandom;
      end
      a_outs_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      checks++; if (a_outs_valid !== (!rst && a_exp_q.size() != 0) || a_outs !== (rst ? '0 : a_head())) begin errors++; $display("FAIL rand_head c%0d got %b/%0h exp head %0h", c, a_outs_valid, a_outs, a_head()); end
      checks++; if (a_ins_ready !== (!rst && a_exp_q.size() != 4)) begin errors++; $display("FAIL rand_ready c%0d got %b size %0d", c, a_ins_ready, a_exp_q.size()); end
      checks++; if (a_occ !== (rst ? 3'd0 : 3'(a_exp_q.size()))) begin errors++; $display("FAIL rand_occ c%0d got %0d exp %0d", c, a_occ, a_exp_q.size()); end
      if (a_ins_valid && !rst && a_exp_q.size() != 4) begin
        tick();
        a_ins_valid = 1'b0;
      end else begin
        tick();
      end
    end
    rst = 1'b0;
    a_ins_valid = 1'b0;
    a_outs_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_ins = '0; a_ins_valid = 1'b0; a_outs_ready = 1'b0;
    b_ins = '0; b_ins_valid = 1'b0; b_outs_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_token();
    test_fill_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_elastic_fifo.md
Name: handshake_elastic_fifo

Overview:
Elastic N-slot FIFO that sits on the receiving end of a dataflow handshake channel. Its typical producers are constant, operator or fork outputs; the block accepts their `outs` / `outs_valid` / `outs_ready` channel as its input. It decouples producer and consumer, breaks the combinational ready path, and re-emits tokens in order on its own output channel. The block is a drop-in buffer between any two handshake units in the dataflow netlist.

Parameters:
- DATA_WIDTH, 32, token payload width in bits.
- NUM_SLOTS, 4, FIFO depth in tokens; legal range 2..256, any integer (power of two not required).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_WIDTH  input token payload.
- ins_valid  input  1  producer offers a token.
- ins_ready  output  1  FIFO can accept a token this cycle.
- outs  output  DATA_WIDTH  head token payload.
- outs_valid  output  1  head token available.
- outs_ready  input  1  consumer accepts the head token.
- occupancy  output  $clog2(NUM_SLOTS+1)  number of tokens currently stored.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Storage:
  - NUM_SLOTS x DATA_WIDTH array.
  - Write pointer wr_ptr, read pointer rd_ptr, counter cnt.
  - Pointers advance modulo NUM_SLOTS: increment, and wrap to 0 when the value equals NUM_SLOTS-1.
  - The array itself is not reset.
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, cnt=0.
  - While rst is high: ins_ready=0, outs_valid=0, outs=0, occupancy=0.
  - Reset mid-operation discards all stored tokens; no token is emitted after reset until a new one is accepted.
- Push: occurs when ins_valid && ins_ready. mem[wr_ptr] <= ins; wr_ptr advances.
- Pop: occurs when outs_valid && outs_ready. rd_ptr advances.
- ins_ready = !rst && (cnt != NUM_SLOTS).
  - Depends only on registered state, never on outs_ready. A full FIFO refuses input even in a cycle where it pops.
- outs_valid = !rst && (cnt != 0).
- outs = outs_valid ? mem[rd_ptr] : 0.
  - No bypass: a token accepted in cycle t is visible on outs with outs_valid=1 in cycle t+1 at the earliest. Minimum latency is 1 cycle.
- Counter update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop in the same cycle (possible when 0<cnt<NUM_SLOTS): cnt unchanged, both pointers advance.
  - neither: hold.
- Empty (cnt=0): no pop is possible; outs=0.
- Full (cnt=NUM_SLOTS): ins_ready=0; a pop in this cycle makes ins_ready=1 next cycle.
- Steady-state throughput is 1 token/cycle when both sides are continuously ready/valid and 0<cnt<NUM_SLOTS.
- occupancy = cnt.
- Protocol rules:
  - The producer holds ins/ins_valid stable until accepted. Behaviour on valid withdrawal is undefined for the producer side only; the FIFO never corrupts stored data.
  - The FIFO itself holds outs/outs_valid stable while outs_valid=1 && outs_ready=0.
- Assertions (simulation only): cnt never exceeds NUM_SLOTS; cnt never underflows; no push when cnt==NUM_SLOTS; no pop when cnt==0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 with no traffic.
  - Required: during reset ins_ready=0, outs_valid=0, outs=0, occupancy=0; after reset ins_ready=1, outs_valid=0.
- Single token, consumer ready: push ins=6'b010101 (21) in cycle t with outs_ready=1.
  - Required: outs_valid=1 and outs=21 in cycle t+1, occupancy 1 in t+1, 0 in t+2.
- Fill and stall (NUM_SLOTS=4, outs_ready=0): push 1,2,3,4, then offer 5.
  - Required: occupancy=4, ins_ready=0, token 5 held off; outs=1 held stable.
  - Then outs_ready=1 for one cycle: token 1 popped; ins_ready=1 next cycle; 5 is accepted after that.
- Wrap-around (NUM_SLOTS=3): stream 10 tokens 0..9 with random outs_ready stalls.
  - Required: output order 0..9 exactly; pointers wrap at 2->0 with no loss or duplication.
- Simultaneous push/pop at cnt=2 with ins_valid=1 and outs_ready=1 for 8 cycles.
  - Required: occupancy stays 2; output sequence equals the input sequence delayed by 2 tokens.
- Reset mid-operation: with 3 tokens stored, assert rst for 1 cycle.
  - Required: occupancy=0 and outs_valid=0 afterwards.
  - A new token 7 then appears on outs one cycle after acceptance; no stale token is ever emitted.
